// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-unit result FIFOs feeding one broadcast bus,
// granted round-robin, with registered CDB and register-bank write outputs.

module cdb_fifo #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_wb,
  output logic              ready,
  output logic              nonempty,
  output logic [TAG_W-1:0]  head_tag,
  output logic [DATA_W-1:0] head_data,
  output logic              head_wb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic              wb;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push, do_pop;

  // Ready looks only at the registered count: a full FIFO refuses even while popping.
  assign ready     = (cnt_q < CNT_W'(DEPTH)) && reset_n;
  assign nonempty  = (cnt_q != '0);
  assign do_push   = push && ready;
  assign do_pop    = pop && nonempty;
  assign head_tag  = mem_q[rd_q].tag;
  assign head_data = mem_q[rd_q].data;
  assign head_wb   = mem_q[rd_q].wb;

  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = '{wb: in_wb, tag: in_tag, data: in_data};
    wr_d  = wr_q + PTR_W'(do_push);
    rd_d  = rd_q + PTR_W'(do_pop);
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

module cdb_arbiter #(
  parameter int N_UNITS    = 4,
  parameter int DATA_W     = 16,
  parameter int TAG_W      = 3,
  parameter int FIFO_DEPTH = 2,
  parameter int SRC_W      = $clog2(N_UNITS)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [N_UNITS-1:0]        req_valid,
  output logic [N_UNITS-1:0]        req_ready,
  input  logic [N_UNITS*TAG_W-1:0]  req_tag,
  input  logic [N_UNITS*DATA_W-1:0] req_data,
  input  logic [N_UNITS-1:0]        req_wb,
  input  logic                      cdb_hold,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src,
  output logic                      rf_we,
  output logic [TAG_W-1:0]          rf_addr,
  output logic [DATA_W-1:0]         rf_data
);
  logic [N_UNITS-1:0][TAG_W-1:0]  tag_in, head_tag;
  logic [N_UNITS-1:0][DATA_W-1:0] data_in, head_data;
  logic [N_UNITS-1:0]             head_wb, nonempty, pop;

  logic                           gnt_vld;
  logic [SRC_W-1:0]               gnt_idx;
  int                             scan;

  logic [SRC_W-1:0]  rr_q, rr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;
  logic              rf_we_q, rf_we_d;
  logic [TAG_W-1:0]  rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

  assign tag_in  = req_tag;
  assign data_in = req_data;

  for (genvar g = 0; g < N_UNITS; g++) begin : g_unit
    assign pop[g] = gnt_vld && (gnt_idx == SRC_W'(g));
    cdb_fifo #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (req_valid[g]),
      .pop       (pop[g]),
      .in_tag    (tag_in[g]),
      .in_data   (data_in[g]),
      .in_wb     (req_wb[g]),
      .ready     (req_ready[g]),
      .nonempty  (nonempty[g]),
      .head_tag  (head_tag[g]),
      .head_data (head_data[g]),
      .head_wb   (head_wb[g])
    );
  end

  // First non-empty unit at or after rr_q, wrapping modulo N_UNITS.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = 0;
    for (int k = 0; k < N_UNITS; k++) begin
      scan = int'(rr_q) + k;
      if (scan >= N_UNITS) scan = scan - N_UNITS;
      if (!gnt_vld && !cdb_hold && nonempty[scan[SRC_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    rr_d        = rr_q;
    cdb_valid_d = gnt_vld;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    rf_we_d     = 1'b0;
    rf_addr_d   = rf_addr_q;
    rf_data_d   = rf_data_q;
    if (gnt_vld) begin
      rr_d       = (gnt_idx == SRC_W'(N_UNITS - 1)) ? '0 : gnt_idx + SRC_W'(1);
      cdb_tag_d  = head_tag[gnt_idx];
      cdb_data_d = head_data[gnt_idx];
      cdb_src_d  = gnt_idx;
      // Tag 0 means "no destination register", so never write it.
      rf_we_d    = head_wb[gnt_idx] && (head_tag[gnt_idx] != '0);
      rf_addr_d  = head_tag[gnt_idx];
      rf_data_d  = head_data[gnt_idx];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_q        <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
    end else begin
      rr_q        <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_data_q   <= rf_data_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;
  assign rf_we     = rf_we_q;
  assign rf_addr   = rf_addr_q;
  assign rf_data   = rf_data_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based model checked every cycle, plus directed
// scenarios with literal expectations and a randomized traffic phase.

module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TW = 3;
  localparam int D  = 2;
  localparam int SW = 2;

  logic            clock = 0;
  logic            reset_n = 0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*TW-1:0] req_tag = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_wb = '0;
  logic            cdb_hold = 0;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [SW-1:0]   cdb_src;
  logic            rf_we;
  logic [TW-1:0]   rf_addr;
  logic [DW-1:0]   rf_data;

  cdb_arbiter #(.N_UNITS(N), .DATA_W(DW), .TAG_W(TW), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_data(req_data), .req_wb(req_wb), .cdb_hold(cdb_hold),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per unit, round-robin pointer, expected outputs.
  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic          wb;
  } ent_t;

  ent_t          mq [N][$];
  int            m_rr = 0;
  int            m_g;
  bit            m_acc [N];
  ent_t          m_e;
  logic          e_valid = 0, e_we = 0;
  logic [TW-1:0] e_tag = 0, e_addr = 0;
  logic [DW-1:0] e_data = 0, e_rdata = 0;
  logic [SW-1:0] e_src = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_rr = 0; e_valid = 0; e_we = 0; e_tag = 0; e_addr = 0;
      e_data = 0; e_rdata = 0; e_src = 0;
    end else begin
      for (int i = 0; i < N; i++) m_acc[i] = req_valid[i] && (mq[i].size() < D);
      m_g = -1;
      if (!cdb_hold)
        for (int k = 0; k < N; k++)
          if (m_g < 0 && mq[(m_rr + k) % N].size() > 0) m_g = (m_rr + k) % N;
      if (m_g >= 0) begin
        m_e = mq[m_g].pop_front();
        e_valid = 1; e_tag = m_e.tag; e_data = m_e.data; e_src = SW'(m_g);
        e_we = m_e.wb && (m_e.tag != 0); e_addr = m_e.tag; e_rdata = m_e.data;
        m_rr = (m_g + 1) % N;
      end else begin
        e_valid = 0; e_we = 0;
      end
      for (int i = 0; i < N; i++)
        if (m_acc[i]) mq[i].push_back('{tag: req_tag[i*TW +: TW], data: req_data[i*DW +: DW], wb: req_wb[i]});
    end
  end

  always @(negedge clock) begin
    logic [N-1:0] e_rdy;
    for (int i = 0; i < N; i++) e_rdy[i] = reset_n && (mq[i].size() < D);
    chk("req_ready", req_ready, e_rdy);
    chk("cdb_valid", cdb_valid, e_valid);
    chk("cdb_tag", cdb_tag, e_tag);
    chk("cdb_data", cdb_data, e_data);
    chk("cdb_src", cdb_src, e_src);
    chk("rf_we", rf_we, e_we);
    chk("rf_addr", rf_addr, e_addr);
    chk("rf_data", rf_data, e_rdata);
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic set_unit(input int u, input bit v, input logic [TW-1:0] t,
                          input logic [DW-1:0] d, input bit wb);
    req_valid[u] = v;
    req_tag[u*TW +: TW] = t;
    req_data[u*DW +: DW] = d;
    req_wb[u] = wb;
  endtask

  task automatic do_reset();
    reset_n = 0; #1;
    chk("rst_valid", cdb_valid, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_ready", req_ready, 0);
    step();
    reset_n = 1; #1;
    chk("rst_rel_ready", req_ready, 4'hF);
    step();
    chk("rst_no_spurious", cdb_valid, 0);
  endtask

  int gap;
  bit seen3;

  initial begin
    repeat (3) step();
    chk("init_valid", cdb_valid, 0);
    chk("init_ready", req_ready, 0);
    reset_n = 1; #1;
    chk("init_ready_rel", req_ready, 4'hF);
    step();

    // single result from unit 2
    set_unit(2, 1, 5, 16'h1234, 1);
    step();
    req_valid = '0;
    step();
    chk("single_valid", cdb_valid, 1);
    chk("single_tag", cdb_tag, 5);
    chk("single_data", cdb_data, 16'h1234);
    chk("single_src", cdb_src, 2);
    chk("single_we", rf_we, 1);
    chk("single_addr", rf_addr, 5);
    step();
    chk("single_done", cdb_valid, 0);
    chk("single_we_off", rf_we, 0);

    // round robin from a fresh pointer
    do_reset();
    for (int i = 0; i < N; i++) set_unit(i, 1, TW'(i + 1), DW'(16'h100 + i), 1);
    step();
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      step();
      chk("rr_valid", cdb_valid, 1);
      chk("rr_src", cdb_src, i);
      chk("rr_data", cdb_data, 32'h100 + i);
    end
    set_unit(0, 1, 6, 16'h0A0A, 1);
    set_unit(3, 1, 7, 16'h3B3B, 1);
    step();
    req_valid = '0;
    step();
    chk("rr_wrap_first", cdb_src, 0);
    step();
    chk("rr_wrap_second", cdb_src, 3);
    chk("rr_wrap_data", cdb_data, 16'h3B3B);

    // write filter: broadcast-only and tag-0 results never write
    set_unit(0, 1, 4, 16'h4444, 0);
    set_unit(1, 1, 0, 16'h5555, 1);
    step();
    req_valid = '0;
    step();
    chk("wf0_valid", cdb_valid, 1);
    chk("wf0_src", cdb_src, 0);
    chk("wf0_we", rf_we, 0);
    step();
    chk("wf1_valid", cdb_valid, 1);
    chk("wf1_src", cdb_src, 1);
    chk("wf1_we", rf_we, 0);

    // back-pressure under hold
    step();
    cdb_hold = 1;
    set_unit(1, 1, 2, 16'h000A, 1);
    step();
    set_unit(1, 1, 2, 16'h000B, 1);
    step();
    chk("bp_full", req_ready[1], 0);
    set_unit(1, 1, 2, 16'h000C, 1);
    step();
    chk("bp_hold_valid", cdb_valid, 0);
    cdb_hold = 0;
    step();
    chk("bp_a", cdb_data, 16'h000A);
    chk("bp_ready_back", req_ready[1], 1);
    step();
    chk("bp_b", cdb_data, 16'h000B);
    req_valid = '0;
    step();
    chk("bp_c", cdb_data, 16'h000C);
    chk("bp_c_valid", cdb_valid, 1);

    // contention: unit 3 pushes every cycle, others once
    for (int i = 0; i < 3; i++) set_unit(i, 1, TW'(i + 1), DW'(16'hC00 + i), 1);
    set_unit(3, 1, 3, 16'hD000, 1);
    gap = 0; seen3 = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      for (int i = 0; i < 3; i++) if (c > 0) req_valid[i] = 0;
      set_unit(3, 1, 3, DW'(16'hD001 + c), 1);
      if (cdb_valid && cdb_src == 3) begin
        if (seen3) chk("u3_gap", gap <= N, 1);
        seen3 = 1; gap = 1;
      end else gap++;
    end
    chk("u3_granted", seen3, 1);
    req_valid = '0;

    // randomized traffic with occasional mid-run reset
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        set_unit(i, ($urandom_range(0, 99) < 45), TW'($urandom), DW'($urandom), bit'($urandom));
      cdb_hold = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 0; #1;
        chk("rand_rst_valid", cdb_valid, 0);
        chk("rand_rst_we", rf_we, 0);
        chk("rand_rst_ready", req_ready, 0);
        #1 reset_n = 1;
      end
      step();
    end
    req_valid = '0;
    cdb_hold = 0;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Parametrised common-data-bus arbiter for the Tomasulo core. Collects completed results from N functional units (add/sub, mul/div, load, …), buffers each unit's results in a small per-unit FIFO, and grants the single CDB to one unit per cycle in round-robin order. The granted result is broadcast as tag + value to the reservation stations and drives the register-bank write port (R1–R7), replacing the single-unit, `done`-edge-triggered write path.

## Interface
Parameters:
- N_UNITS, 4, number of functional-unit result channels (≥2)
- DATA_W, 16, result width
- TAG_W, 3, destination register / tag width (tag 0 = no register)
- FIFO_DEPTH, 2, entries per unit FIFO (power of two, ≥2)
- SRC_W, $clog2(N_UNITS), width of source-unit index

Ports:
- clock  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  N_UNITS  per-unit result valid
- req_ready  out  N_UNITS  per-unit FIFO can accept
- req_tag  in  N_UNITS*TAG_W  destination register per unit (unit i at [i*TAG_W +: TAG_W])
- req_data  in  N_UNITS*DATA_W  result value per unit
- req_wb  in  N_UNITS  1 = result writes register bank (add/sub/mul/div), 0 = broadcast only
- cdb_hold  in  1  suppresses grants; FIFOs still accept
- cdb_valid  out  1  broadcast valid, one cycle per grant
- cdb_tag  out  TAG_W  broadcast tag
- cdb_data  out  DATA_W  broadcast value
- cdb_src  out  SRC_W  index of granted unit
- rf_we  out  1  register-bank write enable
- rf_addr  out  TAG_W  register-bank address
- rf_data  out  DATA_W  register-bank write data

## Operation
- Push: unit i entry {tag, data, wb} written into FIFO i at a rising edge where req_valid[i] && req_ready[i]; req_valid while !req_ready is ignored (producer holds).
- req_ready[i] = (count_i < FIFO_DEPTH) && reset_n; based on registered count only — a full FIFO does not accept even in a cycle it is popped.
- Arbitration each cycle: if !cdb_hold and any FIFO non-empty, grant first non-empty unit scanning rr_ptr, rr_ptr+1, … mod N_UNITS. Granted FIFO pops its head at the edge.
- rr_ptr <= (granted+1) mod N_UNITS on grant; unchanged otherwise.
- Simultaneous push and pop on same non-full FIFO: both occur; count unchanged; order preserved (FIFO head leaves, new entry at tail).
- Outputs registered: on grant edge cdb_valid<=1, cdb_tag/cdb_data/cdb_src <= head entry; rf_we <= wb && (tag != 0); rf_addr <= tag; rf_data <= data. No grant: cdb_valid<=0, rf_we<=0, other outputs hold last value.
- Pointer wrap: read/write pointers are log2(FIFO_DEPTH) bits, wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
- Reset (any time): all FIFOs empty, rr_ptr=0, cdb_valid=0, rf_we=0, cdb_tag/cdb_data/cdb_src/rf_addr/rf_data=0, req_ready=0 while reset_n low; queued results discarded.

## Timing
- Latency push→broadcast: entry accepted at edge k is visible on cdb_* after edge k+1 at the earliest (no combinational bypass).
- Throughput: one broadcast per cycle total; per unit, sustained one per cycle only when it is the sole requester.
- Fairness: with all units continuously non-empty, each unit is granted exactly once every N_UNITS cycles.
- cdb_hold sampled each cycle; hold high at edge k → no grant at edge k, cdb_valid low after k.
- req_ready[i] rises the cycle after the pop that frees a full FIFO.
- Reset assertion clears outputs asynchronously; first push accepted at first rising edge with reset_n high.

## Test plan
- Reset: assert reset_n=0 mid-run → cdb_valid=0, rf_we=0, req_ready=0000 immediately; release → req_ready=1111, no spurious broadcast.
- Single result: unit 2 pushes tag 5, data 0x1234, wb=1 at edge k → after edge k+1 cdb_valid=1, cdb_tag=5, cdb_data=0x1234, cdb_src=2, rf_we=1, rf_addr=5; after k+2 cdb_valid=0.
- Round robin: all 4 units push one entry at same edge → cdb_src 0,1,2,3 on consecutive cycles; then units 0 and 3 push together → order 0 then 3 (rr_ptr wrapped to 0).
- Back-pressure: cdb_hold=1, unit 1 offers 0xA,0xB,0xC on consecutive cycles → 0xA,0xB accepted, req_ready[1]=0 on third; release hold → broadcasts 0xA then 0xB; req_ready[1]=1 the cycle after first pop; 0xC then accepted and broadcast third.
- Write filter: unit 0 pushes wb=0 tag 4 (store/branch), unit 1 pushes wb=1 tag 0 → both give cdb_valid=1 with rf_we=0.
- Contention with fill: unit 3 pushes every cycle while units 0–2 each push once → unit 3 granted at least every 4th cycle, no entry lost or reordered, FIFO 3 never exceeds FIFO_DEPTH.
